// File: rtl/hc_mux_bist_n_if.sv
`default_nettype none
// ============================================================================
// Module   : hc_mux_bist_n_if
// Brief    : Data, select, injection and BIST status bundle for hc_mux_bist_n.
// Revision : 1.0
// ============================================================================
interface hc_mux_bist_n_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic                     test_en_in;
    logic [NUM_IN*WIDTH-1:0]  data_in;
    logic [SEL_W-1:0]         sel;
    logic                     inject_en;
    logic [WIDTH-1:0]         inject_mask;
    logic [WIDTH-1:0]         data_out;
    logic                     bist_busy;
    logic                     bist_done;
    logic                     bist_pass;
    logic                     mux_fault_sticky;
    logic [SEL_W-1:0]         fail_sel;
    logic [7:0]               mismatch_cnt;

    modport master (
        output test_en_in, data_in, sel, inject_en, inject_mask,
        input  data_out, bist_busy, bist_done, bist_pass, mux_fault_sticky,
               fail_sel, mismatch_cnt
    );

    modport slave (
        input  test_en_in, data_in, sel, inject_en, inject_mask,
        output data_out, bist_busy, bist_done, bist_pass, mux_fault_sticky,
               fail_sel, mismatch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hc_mux_bist_n.sv
`default_nettype none
// ============================================================================
// Module   : hc_mux_bist_n
// Brief    : N:1 datapath mux with a structurally distinct spare path and a
//            self-test sequencer that latches a permanent fault flag.
// Revision : 1.0
// ============================================================================
module hc_mux_bist_n #(
    parameter int          WIDTH  = 32,
    parameter int          NUM_IN = 4,
    parameter int          SEL_W  = 2,
    parameter logic [31:0] PAT_A  = 32'hA5A5A5A5
) (
    input  logic                clk,
    input  logic                rst,
    hc_mux_bist_n_if.slave      bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_APPLY = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int IDX_W = SEL_W + 1;
    localparam int N_SLOT = 2 ** SEL_W;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(2 * NUM_IN - 1);

    function automatic logic [WIDTH-1:0] f_expand(input logic [31:0] p);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = p[b % 32];
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] c_PAT = f_expand(PAT_A);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_capture;
    logic [7:0]       r_cnt;
    logic             r_pass;
    logic             r_sticky;
    logic [SEL_W-1:0] r_fail_sel;

    logic             w_busy;
    logic [SEL_W-1:0] w_t;
    logic [WIDTH-1:0] w_pat;
    logic [SEL_W-1:0] w_prim_sel;
    logic [WIDTH-1:0] w_prim_arr [N_SLOT];
    logic [WIDTH-1:0] w_primary;
    logic [WIDTH-1:0] w_spare;
    logic             w_mismatch;
    logic [7:0]       w_cnt_next;
    logic             w_last;

    assign w_busy = (r_state == c_APPLY) || (r_state == c_CHECK);
    assign w_t    = r_idx[SEL_W:1];
    assign w_pat  = r_idx[0] ? ~c_PAT : c_PAT;

    // During self-test the primary sees a synthetic input set: channel t carries
    // the pattern, all others its complement, so a wrong select is detectable.
    for (genvar k = 0; k < N_SLOT; k++) begin : g_prim
        if (k < NUM_IN) begin : g_used
            assign w_prim_arr[k] = w_busy ? ((w_t == SEL_W'(k)) ? w_pat : ~w_pat)
                                          : bus.data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_prim_arr[k] = '0;
        end
    end

    assign w_prim_sel = w_busy ? w_t : bus.sel;
    assign w_primary  = w_prim_arr[w_prim_sel] ^ (bus.inject_en ? bus.inject_mask : '0);

    // Spare path: one-hot decode AND-ed onto each channel, then OR-reduced.
    always_comb begin
        w_spare = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_spare = w_spare | (bus.data_in[k*WIDTH +: WIDTH] & {WIDTH{bus.sel == SEL_W'(k)}});
        end
    end

    assign w_mismatch = (r_state == c_CHECK) && (r_capture != w_pat);
    assign w_cnt_next = (w_mismatch && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;
    assign w_last     = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_capture  <= '0;
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_sticky   <= 1'b0;
            r_fail_sel <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.test_en_in) begin
                        r_state    <= c_APPLY;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_pass     <= 1'b0;
                        r_fail_sel <= '0;
                    end
                end
                c_APPLY: begin
                    r_capture <= w_primary;
                    r_state   <= c_CHECK;
                end
                c_CHECK: begin
                    r_cnt <= w_cnt_next;
                    if (w_mismatch) begin
                        r_sticky <= 1'b1;
                        if (r_cnt == 8'd0) begin
                            r_fail_sel <= w_t;
                        end
                    end
                    if (w_last) begin
                        r_state <= c_DONE;
                        r_pass  <= (w_cnt_next == 8'd0);
                    end else begin
                        r_state <= c_APPLY;
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                c_DONE: begin
                    if (!bus.test_en_in) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.data_out         = (r_sticky || w_busy) ? w_spare : w_primary;
    assign bus.bist_busy        = w_busy;
    assign bus.bist_done        = (r_state == c_DONE);
    assign bus.bist_pass        = r_pass;
    assign bus.mux_fault_sticky = r_sticky;
    assign bus.fail_sel         = r_fail_sel;
    assign bus.mismatch_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hc_mux_bist_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc_mux_bist_n
// Brief    : Scoreboard bench for hc_mux_bist_n (4-input and 3-input builds).
// Revision : 1.0
// ============================================================================
module tb_hc_mux_bist_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hc_mux_bist_n_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus4 ();
    hc_mux_bist_n_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus3 ();

    hc_mux_bist_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .PAT_A(32'hA5A5A5A5)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4));
    hc_mux_bist_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .PAT_A(32'hA5A5A5A5)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3));

    // kind 0: data_out of 4-input build, 1: data_out of 3-input build,
    // 2: full status {busy,done,pass,sticky,fail_sel,cnt}, 3: busy/done only
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [13:0] st;
        string       name;
    } chk_t;

    chk_t q_comb[$];
    chk_t q_done[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] d4 [4];
    logic [31:0] d3 [3];
    logic [31:0] m_mask [8];
    logic        m_sticky, m_pass;
    logic [1:0]  m_fs;
    logic [7:0]  m_cnt;

    // ---------------- monitor ----------------
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        chk_t        c;
        logic [13:0] got;
        got = {bus4.bist_busy, bus4.bist_done, bus4.bist_pass, bus4.mux_fault_sticky,
               bus4.fail_sel, bus4.mismatch_cnt};
        while (q_comb.size() > 0) begin
            c = q_comb.pop_front();
            n_tests++;
            case (c.kind)
                0: if (bus4.data_out !== c.data) begin
                       n_fail++;
                       $display("FAIL %s: data_out got %h expected %h", c.name, bus4.data_out, c.data);
                   end
                1: if (bus3.data_out !== c.data) begin
                       n_fail++;
                       $display("FAIL %s: data_out got %h expected %h", c.name, bus3.data_out, c.data);
                   end
                2: if (got !== c.st) begin
                       n_fail++;
                       $display("FAIL %s: status got %b expected %b", c.name, got, c.st);
                   end
                default: if (got[13:12] !== c.st[13:12]) begin
                       n_fail++;
                       $display("FAIL %s: busy/done got %b expected %b", c.name, got[13:12], c.st[13:12]);
                   end
            endcase
        end
        if (bus4.bist_done && !prev_done) begin
            n_tests++;
            if (q_done.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: status got %b expected no completion", got);
            end else begin
                c = q_done.pop_front();
                if (got !== c.st) begin
                    n_fail++;
                    $display("FAIL %s: status got %b expected %b", c.name, got, c.st);
                end
            end
        end
        prev_done = bus4.bist_done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data;
        bus4.data_in = {d4[3], d4[2], d4[1], d4[0]};
        bus3.data_in = {d3[2], d3[1], d3[0]};
    endtask

    task automatic push(input int kind, input logic [31:0] data, input logic [13:0] st, input string name);
        chk_t c;
        c.kind = kind; c.data = data; c.st = st; c.name = name;
        q_comb.push_back(c);
    endtask

    function automatic logic [13:0] model_st(input logic busy, input logic done);
        return {busy, done, m_pass, m_sticky, m_fs, m_cnt};
    endfunction

    task automatic chk_data4(input logic busy, input string name);
        logic [31:0] e;
        e = d4[bus4.sel];
        if (!(m_sticky || busy) && bus4.inject_en) e = e ^ bus4.inject_mask;
        push(0, e, '0, name);
    endtask

    task automatic chk_data3(input string name);
        push(1, (bus3.sel < 2'd3) ? d3[bus3.sel] : 32'h0, '0, name);
    endtask

    task automatic rand_func(input int n);
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 4; k++) d4[k] = $urandom;
            for (int k = 0; k < 3; k++) d3[k] = $urandom;
            bus4.sel         = 2'($urandom_range(0, 3));
            bus3.sel         = 2'($urandom_range(0, 3));
            bus4.inject_en   = 1'($urandom);
            bus4.inject_mask = $urandom;
            drive_data();
            chk_data4(1'b0, "func4");
            chk_data3("func3");
            tick();
        end
        bus4.inject_en = 1'b0;
    endtask

    // Expected result comes straight from the rule: a check fails iff its
    // APPLY cycle saw a nonzero injection mask.
    task automatic run_bist(input bit hold, input string name);
        int  ec;
        int  efs;
        bit  seen;
        chk_t c;
        ec = 0; efs = 0; seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_mask[i] != 0) begin
                ec++;
                if (!seen) begin efs = i / 2; seen = 1; end
            end
        end
        bus4.test_en_in = 1'b1;
        tick();
        if (!hold) bus4.test_en_in = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            for (int k = 0; k < 4; k++) d4[k] = $urandom;
            bus4.sel = 2'($urandom_range(0, 3));
            if (cyc % 2 == 0) begin
                bus4.inject_en   = (m_mask[cyc/2] != 0);
                bus4.inject_mask = m_mask[cyc/2];
            end else begin
                bus4.inject_en   = 1'($urandom);
                bus4.inject_mask = $urandom;
            end
            drive_data();
            chk_data4(1'b1, "spare_during_busy");
            push(3, '0, {2'b10, 12'h0}, "busy_during_run");
            tick();
        end
        bus4.inject_en = 1'b0;
        m_cnt    = (ec > 255) ? 8'hFF : 8'(ec);
        m_fs     = 2'(efs);
        m_pass   = (ec == 0);
        m_sticky = m_sticky | (ec != 0);
        c.kind = 2; c.data = '0; c.st = model_st(1'b0, 1'b1); c.name = name;
        q_done.push_back(c);
        push(2, '0, model_st(1'b0, 1'b1), name);
        if (hold) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                push(2, '0, model_st(1'b0, 1'b1), "hold_in_done");
            end
            bus4.test_en_in = 1'b0;
            tick();
            push(2, '0, model_st(1'b0, 1'b0), "done_to_idle");
        end
    endtask

    task automatic model_reset;
        m_sticky = 0; m_pass = 0; m_fs = 0; m_cnt = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus4.test_en_in = 0; bus4.sel = 0; bus4.inject_en = 0; bus4.inject_mask = 0;
        bus3.test_en_in = 0; bus3.sel = 0; bus3.inject_en = 0; bus3.inject_mask = 0;
        for (int k = 0; k < 4; k++) d4[k] = 0;
        for (int k = 0; k < 3; k++) d3[k] = 0;
        for (int i = 0; i < 8; i++) m_mask[i] = 0;
        drive_data();
        model_reset();
        tick(); tick();
        rst = 1'b0;
        push(2, '0, 14'h0, "reset_state");

        d4[0] = 32'h11; d4[1] = 32'h22; d4[2] = 32'h33; d4[3] = 32'h44;
        d3[0] = 32'h11; d3[1] = 32'h22; d3[2] = 32'h33;
        drive_data();
        bus4.sel = 2'd2; bus3.sel = 2'd3;
        push(0, 32'h33, '0, "sel2");
        push(1, 32'h0, '0, "n3_sel3_zero");
        tick();
        bus4.sel = 2'd3; bus3.sel = 2'd1;
        push(0, 32'h44, '0, "sel3");
        push(1, 32'h22, '0, "n3_sel1");
        tick();
        rand_func(8);

        run_bist(0, "clean_run");
        tick();
        push(2, '0, model_st(1'b0, 1'b0), "idle_holds_result");
        rand_func(3);

        for (int i = 0; i < 8; i++) m_mask[i] = 32'h1;
        run_bist(0, "inject_all");
        tick();
        rand_func(5);

        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        push(2, '0, 14'h0, "reset_clears_sticky");
        for (int i = 0; i < 8; i++) m_mask[i] = 0;
        m_mask[5] = 32'h1;
        run_bist(0, "inject_check5");
        tick();
        for (int i = 0; i < 8; i++) m_mask[i] = 0;
        run_bist(0, "clean_after_fault");
        tick();

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                m_mask[i] = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : 32'h0;
            run_bist(0, "random_masks");
            tick();
            rand_func(2);
        end

        for (int i = 0; i < 8; i++) m_mask[i] = 0;
        bus4.test_en_in = 1'b1; tick(); bus4.test_en_in = 1'b0;
        for (int j = 0; j < 6; j++) begin
            push(3, '0, {2'b10, 12'h0}, "busy_before_abort");
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        push(2, '0, 14'h0, "abort_by_reset");
        for (int j = 0; j < 3; j++) begin
            tick();
            push(2, '0, 14'h0, "idle_after_abort");
        end

        tick();
        run_bist(1, "held_request_run");
        tick();
        push(2, '0, model_st(1'b0, 1'b0), "no_retrigger");
        run_bist(0, "rerun_after_drop");
        tick(); tick();

        if (q_done.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: %0d completions outstanding, expected 0", q_done.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hc_mux_bist_n.md
Name: hc_mux_bist_n

Overview:
- Parametrised N-input, WIDTH-bit datapath mux with a hardware-redundant spare path and an autonomous BIST sequencer.
- The sequencer walks every select value with complementary test patterns and latches a permanent fault flag on any mismatch; once the flag is set, the output switches to the spare.
- Used wherever the pipeline needs an N:1 select (forwarding, writeback, operand select) under the self-correcting datapath scheme.

Parameters:
- WIDTH, 32, data width in bits.
- NUM_IN, 4, number of data inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- PAT_A, 32'hA5A5A5A5, first BIST pattern; truncated or replicated to WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- test_en_in  in  1  BIST request level.
- data_in  in  NUM_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  functional select.
- inject_en  in  1  fault-injection enable, for verification only.
- inject_mask  in  WIDTH  XORed onto the primary mux output while inject_en=1.
- data_out  out  WIDTH  selected data.
- bist_busy  out  1  sequencer running.
- bist_done  out  1  high in DONE state.
- bist_pass  out  1  last completed run had zero mismatches.
- mux_fault_sticky  out  1  permanent fault flag.
- fail_sel  out  SEL_W  select value of the first mismatch.
- mismatch_cnt  out  8  saturating mismatch count for the last run.

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE; bist_busy=0, bist_done=0, bist_pass=0, mux_fault_sticky=0, fail_sel=0, mismatch_cnt=0. Reset mid-run aborts the run immediately.
- Functional path (combinational, zero latency):
  - primary = data_in[sel] XOR (inject_en ? inject_mask : 0).
  - spare = AND-OR decode of sel, structurally distinct from primary.
  - sel >= NUM_IN gives 0 on both primary and spare.
  - data_out = spare when mux_fault_sticky=1 or bist_busy=1; otherwise primary.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE -> APPLY when test_en_in=1. bist_busy goes high the next cycle. mismatch_cnt is cleared and bist_pass=0 on entry.
- Check index i runs 0..2*NUM_IN-1. Test select t = i>>1. Pattern P = PAT_A when i is even, ~PAT_A when i is odd.
- APPLY: the primary mux internally sees channel t = P, every other channel = ~P, select = t; injection still applies. The primary output is registered at the end of the cycle. Functional data_in and sel are ignored by the primary during BIST.
- CHECK: compare the registered value with P.
  - On mismatch: mismatch_cnt += 1 (saturates at 255) and mux_fault_sticky <= 1.
  - On the first mismatch of the run: fail_sel <= t.
  - Then go to APPLY with i+1, or to DONE after the last check.
- The run takes exactly 4*NUM_IN cycles in APPLY/CHECK.
- DONE: bist_busy=0, bist_done=1, bist_pass = (mismatch_cnt==0). Stay in DONE while test_en_in=1; go to IDLE when test_en_in=0. No auto-retrigger.
- test_en_in changes while busy are ignored; the run always completes.
- mux_fault_sticky is cleared only by rst. A later passing run does not clear it.
- mismatch_cnt, fail_sel and bist_pass hold their values in IDLE until the next run starts.
- inject_en toggling mid-run affects only the checks whose APPLY cycle sees it.

Test Plan:
- Reset, then NUM_IN=4, sel=2, data_in channels = 0x11,0x22,0x33,0x44 -> data_out=0x33 in the same cycle; sel=3 -> 0x44. With NUM_IN=3, sel=3 -> 0.
- test_en_in=1 for one cycle with no injection -> bist_busy high for 16 cycles, then bist_done=1, bist_pass=1, mismatch_cnt=0, mux_fault_sticky=0. data_out tracks the spare during busy.
- inject_en=1, inject_mask=0x1, run BIST -> mismatch_cnt=8, fail_sel=0, mux_fault_sticky=1, bist_pass=0. Afterwards data_out = data_in[sel] with no XOR; the spare is selected.
- inject_en pulsed only during the APPLY cycle of check i=5 -> mismatch_cnt=1, fail_sel=2, sticky=1. A second clean run -> bist_pass=1, sticky stays 1.
- rst asserted at cycle 7 of a run -> the next cycle shows busy=0, done=0, sticky=0, mismatch_cnt=0. A new run starts only on test_en_in=1.
- Hold test_en_in=1 through completion -> the FSM stays in DONE with no second run; drop test_en_in -> IDLE; raise it again -> a new 16-cycle run.
